// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_MIN_PRESCALE = 4;
  localparam int UART_PRESCALE_W   = 5;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register with bit counter; presents the current LSB and flags the last bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign ser_bit  = shreg[0];
  assign ser_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit,
// each bit held for a latched prescale count. Outputs are registered.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      P_DATA,
  input  logic                       Data_Valid,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic [UART_PRESCALE_W-1:0] Prescale,
  output logic                       TX_OUT,
  output logic                       Busy
);

  function automatic logic [UART_PRESCALE_W-1:0] clamp_prescale(
    input logic [UART_PRESCALE_W-1:0] p
  );
    return (p < UART_PRESCALE_W'(UART_MIN_PRESCALE)) ? UART_PRESCALE_W'(UART_MIN_PRESCALE) : p;
  endfunction

  uart_state_e                state, next_state;
  logic [UART_PRESCALE_W-1:0] prescale_q;
  logic [UART_PRESCALE_W-1:0] cyc_cnt;
  logic                       par_en_q;
  logic                       par_bit_q;
  logic                       accept;
  logic                       bit_end;
  logic                       shift;
  logic                       ser_bit;
  logic                       ser_done;
  logic                       tx_next;
  logic                       busy_next;

  assign accept  = (state == IDLE) && Data_Valid;
  assign bit_end = (cyc_cnt == prescale_q - 1'b1);
  assign shift   = (state == DATA) && bit_end;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift    (shift),
    .data     (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Data_Valid) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && ser_done) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line level for the current state; registered below, so the line lags the state by one clock.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = 1'b1;
    case (state)
      IDLE:    busy_next = 1'b0;
      START:   tx_next   = 1'b0;
      DATA:    tx_next   = ser_bit;
      PARITY:  tx_next   = par_bit_q;
      STOP:    tx_next   = 1'b1;
      default: busy_next = 1'b0;
    endcase
  end

  // Frame settings are frozen at accept; parity is taken from the byte as latched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= '0;
      cyc_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
    end else if (accept) begin
      prescale_q <= clamp_prescale(Prescale);
      cyc_cnt    <= '0;
      par_en_q   <= PAR_EN;
      par_bit_q  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end else if (state != IDLE) begin
      cyc_cnt    <= bit_end ? '0 : cyc_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      TX_OUT <= tx_next;
      Busy   <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus predicts frames into a queue, a monitor checks the line.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [4:0]    Prescale;
  logic          TX_OUT;
  logic          Busy;

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  typedef struct {
    int          e;
    int          p;
    int          n;
    logic [7:0]  data;
    logic        par_en;
    logic        par_bit;
    logic [15:0] bits;
  } frame_t;

  frame_t q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ecnt     = 0;
  int     free_edge  = 0;
  int     abort_edge = -1;
  int     acc_cnt  = 0;
  bit     mon_on   = 0;
  bit     active   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) ecnt <= ecnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
    $fatal(1, "watchdog timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Reference model: what the upcoming edge does given the inputs now being driven.
  task automatic model_eval();
    int     ne;
    frame_t f;
    ne = ecnt + 1;
    if (RST) begin
      abort_edge = ne;
      free_edge  = ne + 1;
    end else if (Data_Valid && ne >= free_edge) begin
      f.e       = ne;
      f.p       = (int'(Prescale) < 4) ? 4 : int'(Prescale);
      f.data    = P_DATA;
      f.par_en  = PAR_EN;
      f.par_bit = (($countones(P_DATA) % 2) == 1) ^ PAR_TYP;
      f.n       = f.p * (DW + 2 + (PAR_EN ? 1 : 0));
      f.bits    = '1;
      f.bits[0] = 1'b0;
      for (int k = 0; k < DW; k++) f.bits[1 + k] = P_DATA[k];
      if (PAR_EN) f.bits[1 + DW] = f.par_bit;
      q.push_back(f);
      free_edge = ne + 1 + f.n;
      acc_cnt++;
    end
  endtask

  task automatic cycle();
    model_eval();
    @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    int start;
    int guard;
    start      = acc_cnt;
    guard      = 0;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    while (acc_cnt == start && guard < 3000) begin
      cycle();
      guard++;
    end
    Data_Valid = 1'b0;
    chk("accept_count", acc_cnt - start, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (ecnt + 1 < free_edge && guard < 3000) begin
      cycle();
      guard++;
    end
    chk("wait_idle_bound", (ecnt + 1 >= free_edge), 1);
    cycle();
  endtask

  // Monitor: pops a predicted frame when Busy rises and follows the line bit by bit.
  initial begin
    frame_t      cur;
    int          t;
    int          pos;
    logic [15:0] dec;
    logic [7:0]  decoded;
    dec = '0;
    forever begin
      @(negedge CLK);
      if (mon_on) begin
        t = ecnt;
        if (!active) begin
          if (Busy === 1'b1) begin
            if (q.size() == 0) begin
              chk("spurious_busy", Busy, 1'b0);
            end else begin
              cur    = q.pop_front();
              active = 1;
              dec    = '0;
              chk("start_latency", t, cur.e + 1);
            end
          end else begin
            chk("idle_tx", TX_OUT, 1'b1);
            chk("idle_busy", Busy, 1'b0);
          end
        end
        if (active) begin
          pos = t - (cur.e + 1);
          if (t == abort_edge) begin
            chk("abort_tx", TX_OUT, 1'b1);
            chk("abort_busy", Busy, 1'b0);
            active = 0;
          end else if (pos >= 0 && pos < cur.n) begin
            chk("frame_busy", Busy, 1'b1);
            chk("frame_bit", TX_OUT, cur.bits[pos / cur.p]);
            if (pos % cur.p == cur.p / 2) dec[pos / cur.p] = TX_OUT;
          end else if (pos >= cur.n) begin
            chk("end_tx", TX_OUT, 1'b1);
            chk("end_busy", Busy, 1'b0);
            for (int k = 0; k < DW; k++) decoded[k] = dec[1 + k];
            chk("decode_start", dec[0], 1'b0);
            chk("decode_data", decoded, cur.data);
            if (cur.par_en) chk("decode_parity", dec[1 + DW], cur.par_bit);
            active = 0;
          end
        end
      end
    end
  end

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 5'd8;
    @(negedge CLK);
    repeat (3) cycle();
    RST    = 1'b0;
    mon_on = 1;
    repeat (3) cycle();

    // Directed frames
    send(8'hA5, 1'b1, 1'b0, 5'd8);
    wait_idle();
    send(8'h01, 1'b1, 1'b1, 5'd16);
    wait_idle();
    send(8'hFF, 1'b0, 1'b0, 5'd16);
    wait_idle();

    // Request during a busy frame is dropped, then a held request restarts after one idle cycle
    send(8'hA5, 1'b0, 1'b0, 5'd8);
    repeat (20) cycle();
    P_DATA     = 8'h3C;
    Data_Valid = 1'b1;
    cycle();
    Data_Valid = 1'b0;
    wait_idle();
    repeat (4) cycle();
    begin
      int start;
      int guard;
      start      = acc_cnt;
      guard      = 0;
      P_DATA     = 8'h3C;
      PAR_EN     = 1'b0;
      Prescale   = 5'd8;
      Data_Valid = 1'b1;
      while (acc_cnt - start < 2 && guard < 3000) begin
        cycle();
        guard++;
      end
      Data_Valid = 1'b0;
      chk("held_accepts", acc_cnt - start, 2);
    end
    wait_idle();

    // Reset on frame cycle 30, with a request present: reset wins, then a clean frame
    send(8'h96, 1'b1, 1'b0, 5'd8);
    repeat (30) cycle();
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'h3C;
    cycle();
    RST = 1'b0;
    send(8'h3C, 1'b1, 1'b1, 5'd8);
    wait_idle();

    // Clamped prescale, and a prescale change mid-frame
    send(8'h55, 1'b0, 1'b0, 5'd2);
    repeat (10) cycle();
    Prescale = 5'd8;
    wait_idle();
    send(8'hC3, 1'b1, 1'b0, 5'd0);
    wait_idle();

    // Randomized frames with input noise while busy
    repeat (14) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 20)));
      while (ecnt + 1 < free_edge) begin
        Data_Valid = 1'($urandom);
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        Prescale   = 5'($urandom);
        cycle();
      end
      Data_Valid = 1'b0;
      repeat ($urandom_range(0, 3)) cycle();
    end
    wait_idle();

    repeat (5) cycle();
    chk("queue_drained", q.size(), 0);
    chk("monitor_idle", active, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART link: accepts one parallel byte per handshake and drives the frame on `TX_OUT`. The frame is a start bit, then data bits LSB first, then an optional parity bit, then one stop bit. Each bit is held for `Prescale` clock cycles, matching the oversampling ratio the receiver uses. It sits between the system-side TX FIFO/synchroniser and the pad, in the UART clock domain.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK  input  1  UART clock; all logic on rising edge.`
- `RST  input  1  synchronous, active-high reset.`
- `P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on accept.`
- `Data_Valid  input  1  request; accepted when FSM is IDLE.`
- `PAR_EN  input  1  1 = insert parity bit; sampled on accept.`
- `PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.`
- `Prescale  input  5  clocks per bit; sampled on accept.`
- `TX_OUT  output  1  serial line; idle high; registered.`
- `Busy  output  1  high from first start-bit cycle to last stop-bit cycle; registered.`

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with `Data_Valid`=1 is an accept. On accept, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and the effective prescale, then go to START.
- Effective prescale equals `Prescale`. Values 0..3 are clamped to 4. Later input changes are ignored until the next accept.
- START drives 0.
- DATA drives shift-register bit 0, then shifts right; bit counter runs 0..DATA_WIDTH-1.
- PARITY is entered only if latched `PAR_EN`=1. Even parity: bit = XOR of data. Odd parity: bit = XNOR of data. The value is computed from the latched byte.
- STOP drives 1, then returns to IDLE.
- Each non-IDLE state lasts exactly the effective prescale cycles; the cycle counter wraps to 0 at prescale-1.
- `Data_Valid` outside IDLE is ignored. No queueing, no error flag.
- IDLE drives `TX_OUT`=1 and `Busy`=0.
- Reset values: `TX_OUT`=1, `Busy`=0, state IDLE, all counters and shift register 0.
- Reset mid-frame aborts the frame. `TX_OUT` is 1 on the edge reset is sampled. No partial resume.
- Reset and `Data_Valid` high together: reset wins.

## Timing
- Accept sampled at edge E. At edge E+1, `TX_OUT` falls to 0 and `Busy` rises.
- Frame length N = P·(DATA_WIDTH + 2 + PAR_EN) cycles, where P is the effective prescale.
- `Busy` is high for exactly N cycles and falls at edge E+1+N, when `TX_OUT` is 1 (idle).
- Data bit k drives from edge E+1+P·(1+k) for P cycles.
- Back-to-back: at least one IDLE cycle separates frames. A new accept is possible at edge E+1+N, giving a new start bit at E+2+N.
- Latency from accept to first line transition is 1 cycle.
- No combinational path from any input to `TX_OUT` or `Busy`.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - `UART_MIN_PRESCALE`=4;
  - the prescale width (5).
- The receiver uses the same package.
- Sub-module `uart_tx_serializer`: load/shift register plus DATA_WIDTH bit counter, with outputs `ser_bit` and `ser_done`.
- The top holds the FSM, prescale counter, parity register and output registers.

## Test plan
- 0xA5, `Prescale`=8, `PAR_EN`=1, `PAR_TYP`=0. Line must be 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles. `Busy` is high for 88 cycles.
- 0x01, `Prescale`=16, `PAR_EN`=1, `PAR_TYP`=1. Parity bit must be 0. Frame is 176 cycles; the data bits decode as 0x01.
- 0xFF, `Prescale`=16, `PAR_EN`=0. Frame is 0, eight 1s, 1, for 160 cycles, with no parity slot.
- Pulse `Data_Valid` with 0x3C during a busy frame. No effect: the first frame is unchanged and no second frame is sent. Then hold `Data_Valid` with 0x3C continuously. The next start bit must begin exactly 1 idle cycle after the stop bit.
- Assert `RST` at cycle 30 of a `Prescale`=8 frame. The edge after sampling gives `TX_OUT`=1 and `Busy`=0. A new accept afterwards sends a clean frame.
- `Prescale`=2 with 0x55 and no parity. Each bit lasts 4 cycles and the frame is 40 cycles. Changing `Prescale` to 8 mid-frame must not alter bit length.
